zbus_master: RTL and testbench

ZBUS_MASTER -- requirements
Module: zbus_master

---
 rtl/zbus_master.sv | 155 +++++++++++++++
 tb/tb_zbus_master.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/zbus_master.sv
// Z80-style memory cycle master: derives a CPU clock from the SDRAM clock and
// sequences MREQ/RD/WR through T1..T3, each state one full CPU clock period.
//   state  | meaning
//   S_IDLE | waiting for a request at a CPU clock rise
//   S_T1   | address out; strobes (and write data) asserted at the fall
//   S_T2   | write strobe asserted at the fall for writes
//   S_T3   | strobes released, read data captured, ack pulsed at the fall
module zbus_master #(
    parameter int HALF_PERIOD = 4
) (
    input  logic        i_clk_sdram,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [15:0] i_addr,
    input  logic [7:0]  i_wdata,
    input  logic [7:0]  i_bus_d,
    output logic        o_clk_cpu,
    output logic        o_mreq_n,
    output logic        o_rd_n,
    output logic        o_wr_n,
    output logic [15:0] o_addr,
    output logic [7:0]  o_data,
    output logic        o_data_oe,
    output logic        o_busy,
    output logic        o_ack,
    output logic [7:0]  o_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_T1, S_T2, S_T3} state_t;

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_phase, w_phase_nxt;
    logic        r_clk_cpu, w_clk_cpu_nxt;
    logic        r_we, w_we_nxt;
    logic [7:0]  r_wdata, w_wdata_nxt;
    logic [15:0] r_addr, w_addr_nxt;
    logic [7:0]  r_data, w_data_nxt;
    logic [7:0]  r_rdata, w_rdata_nxt;
    logic        r_mreq_n, w_mreq_n_nxt;
    logic        r_rd_n, w_rd_n_nxt;
    logic        r_wr_n, w_wr_n_nxt;
    logic        r_data_oe, w_data_oe_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_ack, w_ack_nxt;
    logic        w_tick, w_rise, w_fall;

    // Every edge event coincides with the phase wrap, so all outputs move with the toggle.
    assign w_tick = (r_phase == 8'(HALF_PERIOD - 1));
    assign w_rise = w_tick && !r_clk_cpu;
    assign w_fall = w_tick && r_clk_cpu;

    always_comb begin
        w_state_nxt   = r_state;
        w_phase_nxt   = w_tick ? 8'd0 : r_phase + 8'd1;
        w_clk_cpu_nxt = r_clk_cpu ^ w_tick;
        w_we_nxt      = r_we;
        w_wdata_nxt   = r_wdata;
        w_addr_nxt    = r_addr;
        w_data_nxt    = r_data;
        w_rdata_nxt   = r_rdata;
        w_mreq_n_nxt  = r_mreq_n;
        w_rd_n_nxt    = r_rd_n;
        w_wr_n_nxt    = r_wr_n;
        w_data_oe_nxt = r_data_oe;
        w_busy_nxt    = r_busy;
        w_ack_nxt     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rise && i_req) begin
                    w_we_nxt    = i_we;
                    w_addr_nxt  = i_addr;
                    w_wdata_nxt = i_wdata;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_T1;
                end
            end
            S_T1: begin
                if (w_fall) begin
                    w_mreq_n_nxt = 1'b0;
                    if (r_we) begin
                        w_data_oe_nxt = 1'b1;
                        w_data_nxt    = r_wdata;
                    end else begin
                        w_rd_n_nxt = 1'b0;
                    end
                end
                if (w_rise) w_state_nxt = S_T2;
            end
            S_T2: begin
                if (w_fall && r_we) w_wr_n_nxt = 1'b0;
                if (w_rise) w_state_nxt = S_T3;
            end
            S_T3: begin
                if (w_fall) begin
                    w_mreq_n_nxt  = 1'b1;
                    w_rd_n_nxt    = 1'b1;
                    w_wr_n_nxt    = 1'b1;
                    w_data_oe_nxt = 1'b0;
                    if (!r_we) w_rdata_nxt = i_bus_d;
                    w_ack_nxt     = 1'b1;
                    w_busy_nxt    = 1'b0;
                    w_state_nxt   = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk_sdram) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_phase   <= 8'd0;
            r_clk_cpu <= 1'b0;
            r_we      <= 1'b0;
            r_wdata   <= 8'h00;
            r_addr    <= 16'h0000;
            r_data    <= 8'h00;
            r_rdata   <= 8'h00;
            r_mreq_n  <= 1'b1;
            r_rd_n    <= 1'b1;
            r_wr_n    <= 1'b1;
            r_data_oe <= 1'b0;
            r_busy    <= 1'b0;
            r_ack     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_phase   <= w_phase_nxt;
            r_clk_cpu <= w_clk_cpu_nxt;
            r_we      <= w_we_nxt;
            r_wdata   <= w_wdata_nxt;
            r_addr    <= w_addr_nxt;
            r_data    <= w_data_nxt;
            r_rdata   <= w_rdata_nxt;
            r_mreq_n  <= w_mreq_n_nxt;
            r_rd_n    <= w_rd_n_nxt;
            r_wr_n    <= w_wr_n_nxt;
            r_data_oe <= w_data_oe_nxt;
            r_busy    <= w_busy_nxt;
            r_ack     <= w_ack_nxt;
        end
    end

    assign o_clk_cpu = r_clk_cpu;
    assign o_mreq_n  = r_mreq_n;
    assign o_rd_n    = r_rd_n;
    assign o_wr_n    = r_wr_n;
    assign o_addr    = r_addr;
    assign o_data    = r_data;
    assign o_data_oe = r_data_oe;
    assign o_busy    = r_busy;
    assign o_ack     = r_ack;
    assign o_rdata   = r_rdata;

endmodule

// File: tb/tb_zbus_master.sv
// Bench for zbus_master: two instances (HALF_PERIOD 4 and 2) checked every cycle
// against a timeline model expressed as offsets from the acceptance edge.
module tb_zbus_master;

    logic        clk = 1'b0;
    logic        rst4, rst2;
    logic        i_req, i_we;
    logic [15:0] i_addr;
    logic [7:0]  i_wdata, i_bus_d;

    logic        a_clk, a_mreq_n, a_rd_n, a_wr_n, a_oe, a_busy, a_ack;
    logic [15:0] a_addr;
    logic [7:0]  a_data, a_rdata;
    logic        b_clk, b_mreq_n, b_rd_n, b_wr_n, b_oe, b_busy, b_ack;
    logic [15:0] b_addr;
    logic [7:0]  b_data, b_rdata;

    logic        sel2;
    logic        o_clk, o_mreq_n, o_rd_n, o_wr_n, o_oe, o_busy, o_ack;
    logic [15:0] o_addr;
    logic [7:0]  o_data, o_rdata;

    always #5 clk = ~clk;

    zbus_master #(.HALF_PERIOD(4)) u_hp4 (
        .i_clk_sdram(clk), .i_rst(rst4), .i_req(i_req), .i_we(i_we),
        .i_addr(i_addr), .i_wdata(i_wdata), .i_bus_d(i_bus_d),
        .o_clk_cpu(a_clk), .o_mreq_n(a_mreq_n), .o_rd_n(a_rd_n), .o_wr_n(a_wr_n),
        .o_addr(a_addr), .o_data(a_data), .o_data_oe(a_oe), .o_busy(a_busy),
        .o_ack(a_ack), .o_rdata(a_rdata));

    zbus_master #(.HALF_PERIOD(2)) u_hp2 (
        .i_clk_sdram(clk), .i_rst(rst2), .i_req(i_req), .i_we(i_we),
        .i_addr(i_addr), .i_wdata(i_wdata), .i_bus_d(i_bus_d),
        .o_clk_cpu(b_clk), .o_mreq_n(b_mreq_n), .o_rd_n(b_rd_n), .o_wr_n(b_wr_n),
        .o_addr(b_addr), .o_data(b_data), .o_data_oe(b_oe), .o_busy(b_busy),
        .o_ack(b_ack), .o_rdata(b_rdata));

    always_comb begin
        o_clk    = sel2 ? b_clk    : a_clk;
        o_mreq_n = sel2 ? b_mreq_n : a_mreq_n;
        o_rd_n   = sel2 ? b_rd_n   : a_rd_n;
        o_wr_n   = sel2 ? b_wr_n   : a_wr_n;
        o_oe     = sel2 ? b_oe     : a_oe;
        o_busy   = sel2 ? b_busy   : a_busy;
        o_ack    = sel2 ? b_ack    : a_ack;
        o_addr   = sel2 ? b_addr   : a_addr;
        o_data   = sel2 ? b_data   : a_data;
        o_rdata  = sel2 ? b_rdata  : a_rdata;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int hp       = 4;
    int rst_edge = 0;
    bit act      = 0;
    bit rand_bd  = 0;
    int t_acc    = 0;
    logic        m_we;
    logic [7:0]  m_wdata;
    logic [15:0] exp_addr;
    logic [7:0]  exp_data, exp_rdata;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    endtask

    // One SDRAM clock: sample inputs as the edge sees them, advance the model, compare.
    task automatic step();
        logic s_req, s_we, s_rst;
        logic [15:0] s_addr;
        logic [7:0] s_wd, s_bd;
        int k;
        bit rise, e_clk;
        s_req = i_req; s_we = i_we; s_addr = i_addr; s_wd = i_wdata; s_bd = i_bus_d;
        s_rst = sel2 ? rst2 : rst4;
        @(posedge clk);
        cyc++;
        #1;
        if (s_rst) begin
            rst_edge = cyc; act = 0;
            exp_addr = 16'h0000; exp_data = 8'h00; exp_rdata = 8'h00;
        end else begin
            rise = ((cyc - rst_edge) % hp == 0) && (((cyc - rst_edge) / hp) % 2 == 1);
            if (rise && s_req && (!act || cyc > t_acc + 5*hp)) begin
                act = 1; t_acc = cyc; m_we = s_we; m_wdata = s_wd; exp_addr = s_addr;
            end
            if (act && cyc == t_acc + hp && m_we) exp_data = m_wdata;
            if (act && cyc == t_acc + 5*hp && !m_we) exp_rdata = s_bd;
        end
        k = act ? cyc - t_acc : -1;
        e_clk = s_rst ? 1'b0 : (((cyc - rst_edge) / hp) % 2 == 1);
        chk("clk_cpu", o_clk,    e_clk);
        chk("mreq_n",  o_mreq_n, !(k >= hp && k < 5*hp));
        chk("rd_n",    o_rd_n,   !(!m_we && k >= hp && k < 5*hp));
        chk("wr_n",    o_wr_n,   !(m_we && k >= 3*hp && k < 5*hp));
        chk("data_oe", o_oe,     m_we && k >= hp && k < 5*hp);
        chk("busy",    o_busy,   k >= 0 && k < 5*hp);
        chk("ack",     o_ack,    k == 5*hp);
        chk("addr",    o_addr,   exp_addr);
        chk("data",    o_data,   exp_data);
        chk("rdata",   o_rdata,  exp_rdata);
        chk("rd_wr_excl", !(!o_rd_n && !o_wr_n), 1'b1);
        chk("strobe_mreq", !(o_mreq_n && (!o_rd_n || !o_wr_n)), 1'b1);
        if (rand_bd) i_bus_d = 8'($urandom);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Bounded wait for the model's acceptance edge; the DUT must be busy there.
    task automatic wait_accept();
        for (int i = 0; i < 8*hp + 4; i++) begin
            step();
            if (act && t_acc == cyc) break;
        end
        chk("accept_busy", o_busy, 1'b1);
    endtask

    initial begin
        sel2 = 0; rst4 = 1; rst2 = 1;
        i_req = 0; i_we = 0; i_addr = 16'h0000; i_wdata = 8'h00; i_bus_d = 8'h00;
        m_we = 0; m_wdata = 8'h00;
        exp_addr = 16'h0000; exp_data = 8'h00; exp_rdata = 8'h00;
        steps(3);
        rst4 = 0;
        steps(2);

        // single write with inputs disturbed at t+6
        i_req = 1; i_we = 1; i_addr = 16'hC123; i_wdata = 8'h5A;
        wait_accept();
        i_req = 0;
        steps(6);
        i_addr = 16'hFFFF; i_wdata = 8'hFF; i_we = 0;
        steps(18);

        // single read with bus held
        i_bus_d = 8'hA7; i_we = 0; i_addr = 16'h0040; i_req = 1;
        wait_accept();
        i_req = 0;
        steps(24);
        chk("read_rdata", o_rdata, 16'h00A7);

        // back-to-back writes
        i_we = 1; i_addr = 16'h1234; i_wdata = 8'h11; i_req = 1;
        wait_accept();
        i_addr = 16'h5678; i_wdata = 8'h22;
        wait_accept();
        i_req = 0;
        steps(24);

        // reset during a write, asserted for the edge at t+13
        i_we = 1; i_addr = 16'hC123; i_wdata = 8'h5A; i_req = 1;
        wait_accept();
        i_req = 0;
        steps(12);
        rst4 = 1;
        step();
        rst4 = 0;
        step();
        steps(20);

        // randomized transactions with random gaps, bus data and mid-cycle changes
        rand_bd = 1;
        for (int n = 0; n < 12; n++) begin
            i_we = 1'($urandom_range(0, 1)); i_addr = 16'($urandom); i_wdata = 8'($urandom);
            i_req = 1;
            wait_accept();
            i_req = 0;
            steps($urandom_range(1, 8));
            i_we = 1'($urandom_range(0, 1)); i_addr = 16'($urandom); i_wdata = 8'($urandom);
            steps($urandom_range(20, 30));
        end

        // HALF_PERIOD = 2 instance
        rand_bd = 0;
        rst4 = 1; sel2 = 1; hp = 2;
        steps(2);
        rst2 = 0;
        step();
        i_we = 1; i_addr = 16'hBEEF; i_wdata = 8'hC3; i_req = 1;
        wait_accept();
        i_req = 0;
        steps(14);
        rand_bd = 1;
        for (int n = 0; n < 6; n++) begin
            i_we = 1'($urandom_range(0, 1)); i_addr = 16'($urandom); i_wdata = 8'($urandom);
            i_req = 1;
            wait_accept();
            i_req = $urandom_range(0, 1) == 1;
            steps($urandom_range(12, 16));
            i_req = 0;
            steps(14);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
